wishbone_bus_if: RTL and testbench
==================================

Name: wishbone_bus_if

Overview:
- Bridge between one CPU memory port (instruction-fetch or data port of the core) and a Wishbone B3 classic master interface.
- Sits directly downstream of the core's rom/ram pins.
- Converts the core's single-cycle combinational access (ce/addr/we/sel/wdata → rdata) into a multi-cycle Wishbone transaction.
- Raises a pipeline stall request until the transaction completes, and holds read data while the pipeline stays stalled.
- Two instances are used: one for the instruction port, one for the data port.

Parameters:
ADDR_W, 32, width of address bus
DATA_W, 32, width of data buses
SEL_W, 4, byte-select width (DATA_W/8)
STALL_W, 6, width of pipeline stall vector
STALL_BIT, 4, stall-vector bit that freezes the stage owning this port (1 = IF instance, 4 = MEM instance)
TIMEOUT, 255, max cycles waiting for wb_ack_i before abort; 0 disables timeout

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
stall_i  input  STALL_W  pipeline stall vector from pipeline control
flush_i  input  1  pipeline flush; aborts any access
cpu_ce_i  input  1  CPU access request
cpu_addr_i  input  ADDR_W  CPU address
cpu_we_i  input  1  1 = write, 0 = read
cpu_sel_i  input  SEL_W  byte selects
cpu_data_i  input  DATA_W  CPU write data
cpu_data_o  output  DATA_W  read data to CPU
stallreq_o  output  1  stall request to pipeline control
err_o  output  1  one-cycle pulse on timeout abort
wb_adr_o  output  ADDR_W  Wishbone address
wb_dat_o  output  DATA_W  Wishbone write data
wb_dat_i  input  DATA_W  Wishbone read data
wb_we_o  output  1  Wishbone write enable
wb_sel_o  output  SEL_W  Wishbone byte selects
wb_stb_o  output  1  Wishbone strobe
wb_cyc_o  output  1  Wishbone cycle
wb_ack_i  input  1  Wishbone acknowledge

Behaviour:
- Reset (rst=0, async): state=IDLE; all wb_* outputs 0; rd_buf=0; timeout counter=0; err_o=0.
- cpu_data_o and stallreq_o are combinational from state and inputs; they are 0 while in reset.
- wb_* outputs and err_o are registered.

States: IDLE, BUSY, WAIT_STALL.

IDLE:
- If cpu_ce_i=1 and flush_i=0:
  - Next edge: latch cpu_addr/data/we/sel onto wb_*, set wb_stb_o=wb_cyc_o=1, counter=0, go to BUSY.
  - Combinationally: stallreq_o=1, cpu_data_o=0.
- Otherwise: stallreq_o=0, cpu_data_o=0, stay in IDLE.

BUSY:
- wb_ack_i=1:
  - Combinationally: stallreq_o=0; cpu_data_o=wb_dat_i if wb_we_o=0, else 0.
  - Next edge: rd_buf←wb_dat_i; clear wb_stb/cyc/we/sel/adr/dat to 0.
  - Next state: WAIT_STALL if stall_i[STALL_BIT]=1, else IDLE.
- wb_ack_i=0:
  - stallreq_o=1, cpu_data_o=0, counter increments.
  - If TIMEOUT≠0 and counter reaches TIMEOUT-1: clear wb_*, pulse err_o for exactly one cycle, rd_buf←0, go to IDLE.
  - Timeout is an abort; the CPU sees read data 0.
- flush_i=1 (priority over ack and timeout): clear wb_*, rd_buf←0, go to IDLE; stallreq_o=0 that cycle.

WAIT_STALL:
- stallreq_o=0; cpu_data_o=rd_buf.
- When stall_i[STALL_BIT]=0: go to IDLE next edge.
- When flush_i=1: go to IDLE and clear rd_buf.

Rules and corner cases:
- No back-to-back issue from BUSY. A request still present on the IDLE cycle after completion starts a new transaction; minimum transaction length is 2 cycles (issue + ack).
- wb_ack_i outside BUSY is ignored.
- Inputs are sampled only on the IDLE→BUSY edge; later CPU input changes do not affect wb_* during BUSY.
- Async reset mid-transaction drops cyc/stb immediately (no clock needed).

Test Plan:
1. Read, ack after 3 wait cycles:
   - Stimulus: cpu_ce=1, we=0, addr=0x0000_0100, sel=0xF; slave returns 0xDEAD_BEEF.
   - Required: wb_cyc/stb high for 4 cycles with adr=0x100; stallreq high until the ack cycle; cpu_data_o=0xDEADBEEF on the ack cycle; cyc=0 the next cycle.
2. Write:
   - Stimulus: we=1, addr=0x200, data=0x1234_5678, sel=0x3; ack after 1 cycle.
   - Required: wb_dat_o=0x12345678, wb_sel_o=0x3, wb_we_o=1; cpu_data_o stays 0; stallreq drops on ack.
3. Read with stall held:
   - Stimulus: read returns 0xCAFE_0001 while stall_i[STALL_BIT]=1 for 3 cycles after ack.
   - Required: state WAIT_STALL; cpu_data_o=0xCAFE0001 and stallreq_o=0 throughout; IDLE after stall clears.
4. Flush during BUSY:
   - Stimulus: assert flush_i on the 2nd wait cycle.
   - Required: cyc/stb=0 next edge; stallreq_o=0 in the flush cycle; a later ack is ignored; no data delivered.
5. Timeout:
   - Stimulus: TIMEOUT=8, slave never acks.
   - Required: cyc drops after 8 BUSY cycles; err_o high exactly 1 cycle; a new request then issues normally.
6. Async reset:
   - Stimulus: rst low mid-BUSY, between clock edges.
   - Required: wb_cyc_o/wb_stb_o=0 immediately; stallreq_o=0; state IDLE after release.

Source files
------------

// File: rtl/wishbone_bus_if.sv
// Bridges one single-cycle CPU memory port onto a Wishbone B3 classic master,
// stalling the pipeline until the slave acknowledges and buffering read data.
module wishbone_bus_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 4,
  parameter int STALL_W   = 6,
  parameter int STALL_BIT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_we_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rd_buf;
  logic              w_timeout;
  logic              w_issue;

  always_comb begin
    w_next     = r_state;
    w_timeout  = 1'b0;
    w_issue    = 1'b0;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (r_state)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          w_issue    = 1'b1;
          w_next     = BUSY;
          stallreq_o = 1'b1;
        end
      end
      BUSY: begin
        if (flush_i) begin
          w_next = IDLE;
        end else if (wb_ack_i) begin
          cpu_data_o = wb_we_o ? '0 : wb_dat_i;
          w_next     = stall_i[STALL_BIT] ? WAIT_STALL : IDLE;
        end else begin
          stallreq_o = 1'b1;
          if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
            w_timeout = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      WAIT_STALL: begin
        cpu_data_o = r_rd_buf;
        if (flush_i || !stall_i[STALL_BIT]) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // The CPU must see a quiet port while reset is asserted, whatever its inputs do.
    if (!rst) begin
      stallreq_o = 1'b0;
      cpu_data_o = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rd_buf <= '0;
      err_o    <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      r_state <= w_next;
      err_o   <= 1'b0;
      if (w_issue) begin
        wb_adr_o <= cpu_addr_i;
        wb_dat_o <= cpu_data_i;
        wb_we_o  <= cpu_we_i;
        wb_sel_o <= cpu_sel_i;
        wb_stb_o <= 1'b1;
        wb_cyc_o <= 1'b1;
        r_cnt    <= '0;
      end else if (r_state == BUSY) begin
        if (flush_i || wb_ack_i || w_timeout) begin
          wb_adr_o <= '0;
          wb_dat_o <= '0;
          wb_we_o  <= 1'b0;
          wb_sel_o <= '0;
          wb_stb_o <= 1'b0;
          wb_cyc_o <= 1'b0;
          // Aborted accesses (flush or timeout) leave zero in the buffer, never stale data.
          r_rd_buf <= (wb_ack_i && !flush_i) ? wb_dat_i : '0;
          err_o    <= w_timeout && !flush_i;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (r_state == WAIT_STALL && flush_i) begin
        r_rd_buf <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if: read, write, stall hold, flush, timeout
// and asynchronous reset, each scenario in its own task.
module tb_wishbone_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  int checks = 0;
  int failures = 0;

  wishbone_bus_if #(.TIMEOUT(8), .STALL_BIT(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .err_o(err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, take the issue edge, then withdraw it.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr;
    cpu_data_i = data; cpu_sel_i = sel;
    tick();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0;
    cpu_data_i = 32'h0; cpu_sel_i = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = '0; flush_i = 0; cpu_ce_i = 0; cpu_addr_i = 0;
    cpu_we_i = 0; cpu_sel_i = 0; cpu_data_i = 0; wb_dat_i = 0; wb_ack_i = 0;
    #12;
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, err_o} !== 4'b0) begin failures++; $display("[TB] FAIL reset_ctrl actual=%b expected=0000", {wb_cyc_o, wb_stb_o, wb_we_o, err_o}); end
    checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin failures++; $display("[TB] FAIL reset_bus actual=%h expected=0", {wb_adr_o, wb_dat_o, wb_sel_o}); end
    checks++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin failures++; $display("[TB] FAIL reset_cpu actual=%h expected=0", {stallreq_o, cpu_data_o}); end
    @(posedge clk); #1; rst = 1'b1;
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222; #1;
    checks++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin failures++; $display("[TB] FAIL idle_ack_ignored actual=%h expected=0", {stallreq_o, cpu_data_o}); end
    tick();
    checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("[TB] FAIL idle_ack_cyc actual=%b expected=0", wb_cyc_o); end
    wb_ack_i = 1'b0; wb_dat_i = 0;
  endtask

  task automatic test_read();
    int cyc_cnt = 0;
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h100; cpu_sel_i = 4'hF; #1;
    checks++; if ({stallreq_o, cpu_data_o} !== {1'b1, 32'h0}) begin failures++; $display("[TB] FAIL read_issue_comb actual=%h expected=100000000", {stallreq_o, cpu_data_o}); end
    issue(1'b0, 32'h100, 32'h0, 4'hF);
    checks++; if ({wb_adr_o, wb_sel_o, wb_we_o} !== {32'h100, 4'hF, 1'b0}) begin failures++; $display("[TB] FAIL read_bus actual=%h/%h/%b expected=100/f/0", wb_adr_o, wb_sel_o, wb_we_o); end
    for (int i = 0; i < 3; i++) begin
      if (wb_cyc_o && wb_stb_o) cyc_cnt++;
      checks++; if (stallreq_o !== 1'b1) begin failures++; $display("[TB] FAIL read_wait_stall%0d actual=%b expected=1", i, stallreq_o); end
      tick();
    end
    if (wb_cyc_o && wb_stb_o) cyc_cnt++;
    wb_ack_i = 1; wb_dat_i = 32'hDEAD_BEEF; #1;
    checks++; if ({stallreq_o, cpu_data_o} !== {1'b0, 32'hDEAD_BEEF}) begin failures++; $display("[TB] FAIL read_ack actual=%h expected=0deadbeef", {stallreq_o, cpu_data_o}); end
    checks++; if (cyc_cnt !== 4) begin failures++; $display("[TB] FAIL read_cyc_len actual=%0d expected=4", cyc_cnt); end
    tick();
    wb_ack_i = 0; wb_dat_i = 0; #1;
    checks++; if ({wb_cyc_o, wb_stb_o, stallreq_o, cpu_data_o} !== 35'h0) begin failures++; $display("[TB] FAIL read_done actual=%h expected=0", {wb_cyc_o, wb_stb_o, stallreq_o, cpu_data_o}); end
  endtask

  task automatic test_write();
    issue(1'b1, 32'h200, 32'h1234_5678, 4'h3);
    // Changing CPU inputs during BUSY must not reach the bus.
    cpu_data_i = 32'hFFFF_0000; cpu_sel_i = 4'hC; tick();
    checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o} !== {32'h200, 32'h1234_5678, 4'h3, 1'b1, 1'b1}) begin failures++; $display("[TB] FAIL write_bus actual=%h/%h/%h/%b/%b expected=200/12345678/3/1/1", wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o); end
    checks++; if ({stallreq_o, cpu_data_o} !== {1'b1, 32'h0}) begin failures++; $display("[TB] FAIL write_wait actual=%h expected=100000000", {stallreq_o, cpu_data_o}); end
    cpu_data_i = 0; cpu_sel_i = 0;
    wb_ack_i = 1; wb_dat_i = 32'hFFFF_FFFF; #1;
    checks++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin failures++; $display("[TB] FAIL write_ack actual=%h expected=0", {stallreq_o, cpu_data_o}); end
    tick();
    wb_ack_i = 0; wb_dat_i = 0;
    checks++; if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o} !== 38'h0) begin failures++; $display("[TB] FAIL write_clear actual=%h expected=0", {wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o}); end
  endtask

  task automatic test_stall_hold();
    stall_i = 6'b01_0000;
    issue(1'b0, 32'h300, 32'h0, 4'hF);
    wb_ack_i = 1; wb_dat_i = 32'hCAFE_0001; #1;
    checks++; if (cpu_data_o !== 32'hCAFE_0001) begin failures++; $display("[TB] FAIL stall_ack_data actual=%h expected=cafe0001", cpu_data_o); end
    tick();
    wb_ack_i = 0; wb_dat_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({stallreq_o, wb_cyc_o, cpu_data_o} !== {2'b00, 32'hCAFE_0001}) begin failures++; $display("[TB] FAIL stall_hold%0d actual=%h expected=cafe0001", i, {stallreq_o, wb_cyc_o, cpu_data_o}); end
      tick();
    end
    stall_i = '0; #1;
    checks++; if (cpu_data_o !== 32'hCAFE_0001) begin failures++; $display("[TB] FAIL stall_release_data actual=%h expected=cafe0001", cpu_data_o); end
    tick();
    wb_dat_i = 0;
    checks++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin failures++; $display("[TB] FAIL stall_back_idle actual=%h expected=0", {stallreq_o, cpu_data_o}); end
  endtask

  task automatic test_flush();
    issue(1'b0, 32'h400, 32'h0, 4'hF);
    tick();
    flush_i = 1; #1;
    checks++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin failures++; $display("[TB] FAIL flush_comb actual=%h expected=0", {stallreq_o, cpu_data_o}); end
    tick();
    flush_i = 0;
    checks++; if ({wb_cyc_o, wb_stb_o, err_o} !== 3'b000) begin failures++; $display("[TB] FAIL flush_drop actual=%b expected=000", {wb_cyc_o, wb_stb_o, err_o}); end
    wb_ack_i = 1; wb_dat_i = 32'h55AA_55AA; #1;
    checks++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin failures++; $display("[TB] FAIL flush_late_ack actual=%h expected=0", {stallreq_o, cpu_data_o}); end
    tick();
    wb_ack_i = 0; wb_dat_i = 0;
    checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_late_ack_cyc actual=%b expected=0", wb_cyc_o); end
  endtask

  task automatic test_timeout();
    int busy = 0;
    int err_seen = 0;
    issue(1'b0, 32'h500, 32'h0, 4'hF);
    for (int i = 0; i < 20 && wb_cyc_o; i++) begin
      busy++;
      if (err_o) err_seen++;
      tick();
    end
    checks++; if (busy !== 8) begin failures++; $display("[TB] FAIL timeout_len actual=%0d expected=8", busy); end
    checks++; if ({err_o, wb_cyc_o, wb_stb_o} !== 3'b100 || err_seen != 0) begin failures++; $display("[TB] FAIL timeout_err_rise actual=%b early=%0d expected=100", {err_o, wb_cyc_o, wb_stb_o}, err_seen); end
    tick();
    checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL timeout_err_pulse actual=%b expected=0", err_o); end
    issue(1'b1, 32'h600, 32'hA5A5_A5A5, 4'hF);
    checks++; if ({wb_cyc_o, wb_adr_o, wb_dat_o} !== {1'b1, 32'h600, 32'hA5A5_A5A5}) begin failures++; $display("[TB] FAIL timeout_reissue actual=%b/%h/%h expected=1/600/a5a5a5a5", wb_cyc_o, wb_adr_o, wb_dat_o); end
    wb_ack_i = 1; tick(); wb_ack_i = 0;
    checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("[TB] FAIL timeout_reissue_done actual=%b expected=0", wb_cyc_o); end
  endtask

  task automatic test_async_reset();
    issue(1'b0, 32'h700, 32'h0, 4'hF);
    #2;
    checks++; if (wb_cyc_o !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre actual=%b expected=1", wb_cyc_o); end
    cpu_ce_i = 1; rst = 0; #1;
    checks++; if ({wb_cyc_o, wb_stb_o, stallreq_o, cpu_data_o} !== 35'h0) begin failures++; $display("[TB] FAIL areset_drop actual=%h expected=0", {wb_cyc_o, wb_stb_o, stallreq_o, cpu_data_o}); end
    cpu_ce_i = 0;
    tick(); rst = 1; tick();
    wb_ack_i = 1; wb_dat_i = 32'h7777_7777; #1;
    checks++; if ({wb_cyc_o, stallreq_o, cpu_data_o} !== 34'h0) begin failures++; $display("[TB] FAIL areset_idle actual=%h expected=0", {wb_cyc_o, stallreq_o, cpu_data_o}); end
    wb_ack_i = 0; wb_dat_i = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stall_hold();
    test_flush();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
